adder_arbiter: RTL and testbench

Shares one combinational 32-bit flag-producing adder (the gate-level adder with Z/V/C/N outputs) between two requesters. Each requester issues operands over a valid/ready handshake and receives a registered sum and flags over a second valid/ready handshake. The block sits between the adder instance and its clients, such as the ALU sequencer and the address-generation path. It owns the adder's operand inputs exclusively.

---
 rtl/adder_arb_pkg.sv | 53 +++++
 rtl/adder_arb_grant.sv | 49 ++++
 rtl/adder_arbiter.sv | 176 +++++++++++++++++
 tb/tb_adder_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// ---------------------------------------------------------------------------
// adder_arb_pkg
//
// Purpose : Shared definitions for the adder arbiter slice: FSM state
//           encoding, flag bit positions inside resp_flags, default widths
//           and two small helpers used by the top level.
//
// Contents:
//   DEFAULT_WIDTH / DEFAULT_CNT_W : default operand width and counter width
//   arb_state_t                   : IDLE / EXEC / RESP state encoding
//   FLAG_N/Z/C/V                  : bit positions inside the 4-bit flag word
//   packFlags()                   : builds the {N,Z,C,V} flag word
//   oneHot2()                     : 1-bit requester index to 2-bit one-hot
//
// Configuration macro used by this slice: ADDER_ARB_RR_EN
// ---------------------------------------------------------------------------
package adder_arb_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Places each adder flag at its fixed position so callers never have to
   // remember the {N,Z,C,V} ordering themselves.
   function automatic logic [3:0] packFlags(input logic n,
                                            input logic z,
                                            input logic c,
                                            input logic v);
      logic [3:0] flags;
      flags         = 4'b0000;
      flags[FLAG_N] = n;
      flags[FLAG_Z] = z;
      flags[FLAG_C] = c;
      flags[FLAG_V] = v;
      return flags;
   endfunction

   // Requester index to the matching one-hot handshake bit.
   function automatic logic [1:0] oneHot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/adder_arb_grant.sv
// ---------------------------------------------------------------------------
// adder_arb_grant
//
// Purpose : Purely combinational two-way arbiter. Picks which requester is
//           offered req_ready while the arbiter sits in IDLE.
//
// Ports   :
//   i_reqValid   in  2 : request valid, one bit per requester
//   i_lastGrant  in  1 : requester that completed most recently
//   o_grant      out 1 : index of the winning requester
//   o_grantValid out 1 : at least one request is valid (o_grant meaningful)
//
// Configuration:
//   ADDER_ARB_RR_EN defined   : round-robin, on contention the requester that
//                               was not served last wins.
//   ADDER_ARB_RR_EN undefined : fixed priority, requester 0 always wins and
//                               i_lastGrant is ignored.
// ---------------------------------------------------------------------------
module adder_arb_grant (
   input  logic [1:0] i_reqValid,
   input  logic       i_lastGrant,
   output logic       o_grant,
   output logic       o_grantValid
);

`ifdef ADDER_ARB_RR_EN
   // Round-robin: on contention hand the adder to whoever did not have it
   // last; a single valid request always wins outright.
   always_comb begin
      o_grantValid = |i_reqValid;
      if (&i_reqValid) begin
         o_grant = ~i_lastGrant;
      end else begin
         o_grant = ~i_reqValid[0];
      end
   end
`else
   // Fixed priority: requester 0 wins whenever it is asking. The history
   // input is kept on the port so both builds share one interface.
   logic w_unusedLastGrant;
   assign w_unusedLastGrant = i_lastGrant;

   always_comb begin
      o_grantValid = |i_reqValid;
      o_grant      = ~i_reqValid[0];
   end
`endif

endmodule

// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
//
// Purpose : Shares one external combinational flag-producing adder between
//           two requesters. Operands arrive on a valid/ready handshake, are
//           latched and driven onto the adder for one cycle, and the sum and
//           flags are returned on a second valid/ready handshake. Each
//           operation takes three cycles: accept, EXEC, RESP.
//
// Parameters:
//   WIDTH : operand and sum width, must match the adder instance
//   CNT_W : width of each per-requester completion counter
//
// Ports   :
//   clk, reset           : clock, asynchronous active-high reset
//   req_valid/req_ready  : request handshake, one bit per requester
//   req_a, req_b         : operands, requester 1 in the upper WIDTH bits
//   resp_valid/resp_ready: response handshake, resp_valid one-hot or zero
//   resp_sum, resp_flags : registered result, flags ordered {N,Z,C,V}
//   add_a, add_b         : operands driven into the shared adder
//   add_sum, add_z/v/c/n : adder outputs
//   busy                 : any state other than IDLE
//   done_cnt             : per-requester completed responses, req 1 on top
//
// Configuration macro: ADDER_ARB_RR_EN (round-robin arbitration, see
// adder_arb_grant). Default build is fixed priority to requester 0.
// ---------------------------------------------------------------------------
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         req_valid,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   output logic [1:0]         req_ready,
   output logic [1:0]         resp_valid,
   input  logic [1:0]         resp_ready,
   output logic [WIDTH-1:0]   resp_sum,
   output logic [3:0]         resp_flags,
   output logic [WIDTH-1:0]   add_a,
   output logic [WIDTH-1:0]   add_b,
   input  logic [WIDTH-1:0]   add_sum,
   input  logic               add_z,
   input  logic               add_v,
   input  logic               add_c,
   input  logic               add_n,
   output logic               busy,
   output logic [2*CNT_W-1:0] done_cnt
);

   arb_state_t       r_state;
   arb_state_t       w_nextState;
   logic [WIDTH-1:0] r_opA;
   logic [WIDTH-1:0] r_opB;
   logic             r_grant;
   logic             r_lastGrant;
   logic [WIDTH-1:0] r_respSum;
   logic [3:0]       r_respFlags;
   logic [CNT_W-1:0] r_doneCnt0;
   logic [CNT_W-1:0] r_doneCnt1;

   logic             w_grant;
   logic             w_grantValid;
   logic             w_accept;
   logic             w_respDone;
   logic [WIDTH-1:0] w_selA;
   logic [WIDTH-1:0] w_selB;

   adder_arb_grant u_grant (
      .i_reqValid  (req_valid),
      .i_lastGrant (r_lastGrant),
      .o_grant     (w_grant),
      .o_grantValid(w_grantValid)
   );

   // Only the winner sees ready, and only while nothing is in flight, so a
   // request can never be accepted while the adder is still in use.
   assign req_ready = ((r_state == IDLE) && w_grantValid) ? oneHot2(w_grant) : 2'b00;

   assign w_accept   = (r_state == IDLE) && (|(req_valid & req_ready));
   assign w_respDone = (r_state == RESP) && resp_ready[r_grant];

   // Operand mux for the winner; requester 1 lives in the upper half.
   assign w_selA = w_grant ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
   assign w_selB = w_grant ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

   // Next-state decode. EXEC always lasts exactly one cycle because the
   // adder is combinational; RESP waits for the granted requester only.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextState = EXEC;
            end
         end
         EXEC: begin
            w_nextState = RESP;
         end
         RESP: begin
            if (w_respDone) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State register. Reset in any state abandons the current operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Operand and grant capture on acceptance. The operand registers keep
   // driving the adder afterwards so add_a/add_b stay quiet in IDLE/RESP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_opA   <= '0;
         r_opB   <= '0;
         r_grant <= 1'b0;
      end else if (w_accept) begin
         r_opA   <= w_selA;
         r_opB   <= w_selB;
         r_grant <= w_grant;
      end
   end

   // Result capture at the end of EXEC. The registered copy stays put until
   // the next EXEC so the response is stable under backpressure.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_respSum   <= '0;
         r_respFlags <= 4'b0000;
      end else if (r_state == EXEC) begin
         r_respSum   <= add_sum;
         r_respFlags <= packFlags(add_n, add_z, add_c, add_v);
      end
   end

   // Completion bookkeeping. lastGrant starts at 1 so that round-robin
   // favours requester 0 on the first contention after reset. Counters wrap
   // naturally at 2^CNT_W.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lastGrant <= 1'b1;
         r_doneCnt0  <= '0;
         r_doneCnt1  <= '0;
      end else if (w_respDone) begin
         r_lastGrant <= r_grant;
         if (r_grant) begin
            r_doneCnt1 <= r_doneCnt1 + CNT_W'(1);
         end else begin
            r_doneCnt0 <= r_doneCnt0 + CNT_W'(1);
         end
      end
   end

   assign add_a      = r_opA;
   assign add_b      = r_opB;
   assign resp_sum   = r_respSum;
   assign resp_flags = r_respFlags;
   assign resp_valid = (r_state == RESP) ? oneHot2(r_grant) : 2'b00;
   assign busy       = (r_state != IDLE);
   assign done_cnt   = {r_doneCnt1, r_doneCnt0};

endmodule

// File: tb/tb_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_arbiter
//
// Purpose : Directed bench for adder_arbiter. Provides a behavioural model
//           of the shared 32-bit flag-producing adder, drives both
//           requesters, and compares every response against a scoreboard of
//           expected results computed from the operands.
//
// The DUT is built with CNT_W=2 so the completion counters wrap quickly.
// Honours ADDER_ARB_RR_EN for the expected contention grant order.
// ---------------------------------------------------------------------------
module tb_adder_arbiter;

   localparam int W  = 32;
   localparam int CW = 2;

`ifdef ADDER_ARB_RR_EN
   localparam bit RR_MODE = 1'b1;
`else
   localparam bit RR_MODE = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic [1:0]     req_valid;
   logic [2*W-1:0] req_a;
   logic [2*W-1:0] req_b;
   logic [1:0]     req_ready;
   logic [1:0]     resp_valid;
   logic [1:0]     resp_ready;
   logic [W-1:0]   resp_sum;
   logic [3:0]     resp_flags;
   logic [W-1:0]   add_a;
   logic [W-1:0]   add_b;
   logic [W-1:0]   add_sum;
   logic           add_z;
   logic           add_v;
   logic           add_c;
   logic           add_n;
   logic           busy;
   logic [2*CW-1:0] done_cnt;

   typedef struct packed {
      logic         req;
      logic [W-1:0] sum;
      logic [3:0]   flags;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   mCnt[2];
   logic mLast;

   always #5 clk = ~clk;

   // Behavioural stand-in for the shared gate-level adder.
   logic [W:0] w_full;
   assign w_full  = {1'b0, add_a} + {1'b0, add_b};
   assign add_sum = w_full[W-1:0];
   assign add_c   = w_full[W];
   assign add_z   = (w_full[W-1:0] == '0);
   assign add_n   = w_full[W-1];
   assign add_v   = (add_a[W-1] == add_b[W-1]) && (w_full[W-1] != add_a[W-1]);

   adder_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_sum  (resp_sum),
      .resp_flags(resp_flags),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_sum   (add_sum),
      .add_z     (add_z),
      .add_v     (add_v),
      .add_c     (add_c),
      .add_n     (add_n),
      .busy      (busy),
      .done_cnt  (done_cnt)
   );

   function automatic logic [1:0] oneHot(input logic r);
      return r ? 2'b10 : 2'b01;
   endfunction

   function automatic int cntOf(input int r);
      return int'(done_cnt[r*CW +: CW]);
   endfunction

   // Reference result: expected sum and {N,Z,C,V} straight from the operands.
   function automatic exp_t refOp(input logic r, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] full;
      exp_t       e;
      full     = {1'b0, a} + {1'b0, b};
      e.req    = r;
      e.sum    = full[W-1:0];
      e.flags[3] = full[W-1];
      e.flags[2] = (full[W-1:0] == '0);
      e.flags[1] = full[W];
      e.flags[0] = (a[W-1] & b[W-1] & ~full[W-1]) | (~a[W-1] & ~b[W-1] & full[W-1]);
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyReset();
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      mCnt[0] = 0;
      mCnt[1] = 0;
      mLast   = 1'b1;
      sb.delete();
   endtask

   // Drive one request and wait (bounded) for it to be accepted. Returns at
   // accept edge + 1, i.e. in the EXEC cycle.
   task automatic applyStimulus(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                                output bit accepted);
      bit seen;
      seen = 1'b0;
      if (r) begin
         req_a[2*W-1:W] = a;
         req_b[2*W-1:W] = b;
      end else begin
         req_a[W-1:0] = a;
         req_b[W-1:0] = b;
      end
      req_valid[r] = 1'b1;
      for (int n = 0; n < 20; n++) begin
         #1;
         if (req_ready[r]) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (seen) begin
         checkOutput("ready_onehot", 32'(req_ready), 32'(oneHot(r)));
         @(posedge clk); #1;
         sb.push_back(refOp(r, a, b));
      end
      req_valid[r] = 1'b0;
      checkOutput("accept_seen", 32'(seen), 32'd1);
      accepted = seen;
   endtask

   // Wait (bounded) for a response and compare it with the scoreboard head.
   task automatic awaitResponse(output exp_t e, output int lat);
      int n;
      n = 0;
      e = '0;
      while (resp_valid == 2'b00 && n < 12) begin
         @(posedge clk); #1;
         n++;
      end
      lat = n;
      checkOutput("resp_arrives", 32'(resp_valid != 2'b00), 32'd1);
      if (resp_valid != 2'b00) begin
         if (sb.size() == 0) begin
            checkOutput("resp_expected", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            checkOutput("resp_valid", 32'(resp_valid), 32'(oneHot(e.req)));
            checkOutput("resp_sum", resp_sum, e.sum);
            checkOutput("resp_flags", 32'(resp_flags), 32'(e.flags));
         end
      end
   endtask

   task automatic completeResponse(input logic r);
      resp_ready[r] = 1'b1;
      @(posedge clk); #1;
      resp_ready[r] = 1'b0;
      mCnt[r] = (mCnt[r] + 1) % 4;
      mLast   = r;
      checkOutput("done_cnt", 32'(cntOf(int'(r))), 32'(mCnt[r]));
      checkOutput("idle_after_resp", 32'({busy, resp_valid}), 32'd0);
   endtask

   task automatic doOp(input logic r, input logic [W-1:0] a, input logic [W-1:0] b);
      bit   acc;
      exp_t e;
      int   lat;
      applyStimulus(r, a, b, acc);
      if (acc) begin
         checkOutput("exec_busy", 32'(busy), 32'd1);
         checkOutput("exec_no_resp", 32'(resp_valid), 32'd0);
         checkOutput("exec_add_a", add_a, a);
         checkOutput("exec_add_b", add_b, b);
         awaitResponse(e, lat);
         checkOutput("resp_latency", 32'(lat), 32'd1);
         completeResponse(r);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      exp_t e;
      int   lat;
      logic pred;
      logic w;
      logic [W-1:0] c0a, c0b, c1a, c1b;
      int   seqTbl[5];

      seqTbl     = '{1, 2, 3, 0, 1};
      reset      = 1'b1;
      req_valid  = 2'b00;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 2'b00;
      mCnt[0]    = 0;
      mCnt[1]    = 0;
      mLast      = 1'b1;

      // Reset state
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_sum", resp_sum, 32'd0);
      checkOutput("rst_flags", 32'(resp_flags), 32'd0);
      checkOutput("rst_done_cnt", 32'(done_cnt), 32'd0);
      checkOutput("rst_add_a", add_a, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      checkOutput("idle_no_ready", 32'(req_ready), 32'd0);
      checkOutput("idle_not_busy", 32'(busy), 32'd0);

      // Overflow case on requester 0
      $display("[TB] overflow case");
      doOp(1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
      checkOutput("ovf_sum_held", resp_sum, 32'h8000_0000);
      checkOutput("ovf_flags_held", 32'(resp_flags), 32'b1001);

      // Zero-with-carry case on requester 1
      $display("[TB] zero with carry case");
      doOp(1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
      checkOutput("zc_sum_held", resp_sum, 32'h0000_0000);
      checkOutput("zc_flags_held", 32'(resp_flags), 32'b0110);
      checkOutput("zc_done1", 32'(cntOf(1)), 32'd1);

      // Contention: both requesters hold valid for four operations
      $display("[TB] contention");
      c0a = 32'h0000_0010; c0b = 32'h0000_0020;
      c1a = 32'h8000_0000; c1b = 32'h8000_0000;
      pred = mLast;
      for (int k = 0; k < 4; k++) begin
         w = RR_MODE ? ~pred : 1'b0;
         if (w) sb.push_back(refOp(1'b1, c1a, c1b));
         else   sb.push_back(refOp(1'b0, c0a, c0b));
         pred = w;
      end
      req_a      = {c1a, c0a};
      req_b      = {c1b, c0b};
      req_valid  = 2'b11;
      resp_ready = 2'b11;
      for (int k = 0; k < 4; k++) begin
         awaitResponse(e, lat);
         if (resp_valid == 2'b00) break;
         @(posedge clk); #1;
         mCnt[e.req] = (mCnt[e.req] + 1) % 4;
         mLast       = e.req;
         checkOutput("cont_done_cnt", 32'(cntOf(int'(e.req))), 32'(mCnt[e.req]));
      end
      req_valid  = 2'b00;
      resp_ready = 2'b00;
      sb.delete();
      @(posedge clk); #1;
      checkOutput("cont_idle", 32'(busy), 32'd0);

      // Backpressure: hold off resp_ready for five cycles
      $display("[TB] backpressure");
      begin
         bit acc;
         applyStimulus(1'b0, 32'h1234_5678, 32'h0F0F_0F0F, acc);
         req_a[2*W-1:W] = 32'h0000_0001;
         req_b[2*W-1:W] = 32'h0000_0002;
         req_valid[1]   = 1'b1;
         resp_ready[1]  = 1'b1;
         awaitResponse(e, lat);
         for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checkOutput("bp_resp_valid", 32'(resp_valid), 32'b01);
            checkOutput("bp_sum", resp_sum, 32'h2143_6587);
            checkOutput("bp_flags", 32'(resp_flags), 32'(e.flags));
            checkOutput("bp_busy", 32'(busy), 32'd1);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
         end
         req_valid[1]  = 1'b0;
         resp_ready[1] = 1'b0;
         completeResponse(1'b0);
      end

      // Reset in the middle of EXEC
      $display("[TB] reset mid EXEC");
      begin
         bit acc;
         applyStimulus(1'b1, 32'h0000_00FF, 32'h0000_0001, acc);
         checkOutput("mid_in_exec", 32'(busy), 32'd1);
         reset = 1'b1;
         #1;
         checkOutput("mid_busy", 32'(busy), 32'd0);
         checkOutput("mid_resp_valid", 32'(resp_valid), 32'd0);
         checkOutput("mid_sum", resp_sum, 32'd0);
         checkOutput("mid_flags", 32'(resp_flags), 32'd0);
         checkOutput("mid_done_cnt", 32'(done_cnt), 32'd0);
         checkOutput("mid_add_a", add_a, 32'd0);
         sb.delete();
         mCnt[0] = 0;
         mCnt[1] = 0;
         mLast   = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
         for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checkOutput("mid_no_resp", 32'(resp_valid), 32'd0);
         end
         doOp(1'b0, 32'h0000_0003, 32'h0000_0004);
         checkOutput("mid_recover_sum", resp_sum, 32'h0000_0007);
      end

      // Counter wrap with CNT_W=2
      $display("[TB] counter wrap");
      applyReset();
      for (int k = 0; k < 5; k++) begin
         doOp(1'b0, 32'h1111_1111 * (k + 1), 32'h0000_00A0 + k);
         checkOutput("wrap_seq", 32'(cntOf(0)), 32'(seqTbl[k]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
